// File: rtl/bcd_counter_multi.sv
// Multi-digit packed-BCD up/down counter with validated load and combinational carry/borrow out.
// One-cycle latency; define BCD_SAT_EN to hold at 99..9 / 00..0 instead of wrapping.
module bcd_counter_multi #(
  parameter int                    DIGITS  = 4,
  parameter logic [4*DIGITS-1:0]   RST_VAL = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Clr,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Din,
  input  logic                  Cin,
  input  logic                  Up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  Cout,
  output logic                  Load_err
);

  logic [4*DIGITS-1:0] cnt_nxt;
  logic                at_limit;
  logic                din_ok;
  logic                ripple;
  logic [3:0]          dig;

  // A digit moves only while every lower digit sits at its terminal value;
  // the ripple flag left after the top digit is the all-9 / all-0 limit.
  always_comb begin
    cnt_nxt = q;
    ripple  = 1'b1;
    dig     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = q[4*k +: 4];
      if (ripple) begin
        if (Up) cnt_nxt[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
        else    cnt_nxt[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      ripple = ripple & (Up ? (dig == 4'd9) : (dig == 4'd0));
    end
    at_limit = ripple;
  end

  always_comb begin
    din_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (Din[4*k +: 4] > 4'd9) din_ok = 1'b0;
    end
  end

  assign Cout = Cin & ~Rst & ~Clr & ~Load & at_limit;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q        <= RST_VAL;
      Load_err <= 1'b0;
    end else if (Clr) begin
      q        <= RST_VAL;
      Load_err <= 1'b0;
    end else if (Load) begin
      if (din_ok) q <= Din;
      Load_err <= ~din_ok;
    end else begin
      Load_err <= 1'b0;
`ifdef BCD_SAT_EN
      if (Cin && !at_limit) q <= cnt_nxt;
`else
      if (Cin) q <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench for bcd_counter_multi (DIGITS=4); saturating checks build when BCD_SAT_EN is defined.
module tb_bcd_counter_multi;

  logic        Clk = 1'b0;
  logic        Rst, Clr, Load, Cin, Up;
  logic [15:0] Din;
  logic [15:0] q;
  logic        Cout, Load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cout_hits;
  int model;

  bcd_counter_multi #(.DIGITS(4), .RST_VAL(16'h0000)) dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .Load(Load), .Din(Din),
    .Cin(Cin), .Up(Up), .q(q), .Cout(Cout), .Load_err(Load_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; Clr = 1'b0; Load = 1'b1; Din = 16'h1234; Cin = 1'b1; Up = 1'b1;

    // Reset beats load and count
    tick;
    chk("rst_q", q, 16'h0000);
    chk("rst_err", Load_err, 1'b0);
    Up = 1'b0; #1;
    chk("rst_masks_cout", Cout, 1'b0);
    tick;
    chk("rst_hold_q", q, 16'h0000);

    Rst = 1'b0; Load = 1'b0; Cin = 1'b0; Up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_hold", q, 16'h0000);
    end

    // Full up-count sweep through the 9999 -> 0000 wrap
    Cin = 1'b1; Up = 1'b1; model = 0; cout_hits = 0;
    for (int i = 0; i < 10000; i++) begin
      #1;
      chk("up_cout", Cout, (model == 9999) ? 1'b1 : 1'b0);
      if (Cout === 1'b1) cout_hits++;
      tick;
      model = (model + 1) % 10000;
      chk("up_q", q, to_bcd(model));
    end
    chk("up_cout_hits", cout_hits, 1);

    // Down-count with borrow across digits and 0000 -> 9999 wrap
    Load = 1'b1; Din = 16'h0100; Up = 1'b0; #1;
    chk("load_masks_cout", Cout, 1'b0);
    tick;
    chk("load_0100", q, 16'h0100);
    chk("load_ok_err", Load_err, 1'b0);
    Load = 1'b0;
    tick;
    chk("dn_0099", q, 16'h0099);
    tick;
    chk("dn_0098", q, 16'h0098);
    Load = 1'b1; Din = 16'h0000;
    tick;
    Load = 1'b0; #1;
    chk("dn_cout_0000", Cout, 1'b1);
    tick;
`ifdef BCD_SAT_EN
    chk("dn_sat_0000", q, 16'h0000);
    Load = 1'b1; Din = 16'h9999;
    tick;
    Load = 1'b0;
`else
    chk("dn_wrap_9999", q, 16'h9999);
`endif
    #1;
    chk("dn_no_cout_9999", Cout, 1'b0);
    Up = 1'b1; #1;
    chk("up_cout_9999", Cout, 1'b1);
    Cin = 1'b0; #1;
    chk("cin0_no_cout", Cout, 1'b0);

    // Rejected loads leave q alone and flag for exactly one cycle
    Load = 1'b1; Din = 16'h12A4; Cin = 1'b1;
    tick;
    chk("bad_load_q", q, 16'h9999);
    chk("bad_load_err", Load_err, 1'b1);
    Load = 1'b0; Cin = 1'b0;
    tick;
    chk("bad_load_err_clr", Load_err, 1'b0);
    chk("bad_load_q_hold", q, 16'h9999);
    Load = 1'b1; Din = 16'hA000;
    tick;
    chk("bad_top_err", Load_err, 1'b1);
    Din = 16'h9909;
    tick;
    chk("good_after_bad_err", Load_err, 1'b0);
    chk("good_after_bad_q", q, 16'h9909);

    // Clear beats load and count; then load beats count
    Clr = 1'b1; Load = 1'b1; Cin = 1'b1; Din = 16'h1234;
    tick;
    chk("clr_q", q, 16'h0000);
    Clr = 1'b0;
    tick;
    chk("load_over_cin", q, 16'h1234);
    Din = 16'hF000;
    tick;
    chk("err_before_clr", Load_err, 1'b1);
    Clr = 1'b1;
    tick;
    chk("clr_drops_err", Load_err, 1'b0);
    chk("clr_q2", q, 16'h0000);

    // Direction change and mid-count reset
    Clr = 1'b0; Load = 1'b1; Din = 16'h1239;
    tick;
    Load = 1'b0; Up = 1'b1;
    tick;
    chk("up_carry_1240", q, 16'h1240);
    Up = 1'b0;
    tick;
    chk("dn_borrow_1239", q, 16'h1239);
    Rst = 1'b1;
    tick;
    chk("midcount_rst", q, 16'h0000);
    Rst = 1'b0; Cin = 1'b0;

`ifdef BCD_SAT_EN
    Load = 1'b1; Din = 16'h9999;
    tick;
    Load = 1'b0; Cin = 1'b1; Up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat_up_cout", Cout, 1'b1);
      tick;
      chk("sat_up_q", q, 16'h9999);
    end
    Load = 1'b1; Din = 16'h0000;
    tick;
    Load = 1'b0; Up = 1'b0; #1;
    chk("sat_dn_cout", Cout, 1'b1);
    tick;
    chk("sat_dn_q", q, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
